// File: rtl/iob_wb_pkg.sv
// Shared definitions for the IOb-to-Wishbone master bridge: FSM encoding,
// timeout counter sizing and the error-counter saturation limit.
package iob_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STB  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int         ERR_CNT_W   = 8;
    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Width of a counter that must reach TIMEOUT; never narrower than one bit
    function automatic int tmo_cnt_w(input int timeout);
        return ($clog2(timeout + 1) < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/iob_wb_timeout.sv
// Bus-cycle watchdog: clears on a new cycle, counts enabled cycles, and
// pulses expire_o on the enabled cycle that would bring the count to TIMEOUT.
// TIMEOUT = 0 removes the watchdog entirely.
module iob_wb_timeout
    import iob_wb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = tmo_cnt_w(TIMEOUT);

    if (TIMEOUT == 0) begin : g_bypass
        logic unused_tmo;
        assign unused_tmo = ^{clk_i, arst_n_i, clr_i, en_i};
        assign expire_o   = 1'b0;
    end else begin : g_count
        logic [CNT_W-1:0] cnt;

        // Count cycles of an outstanding bus cycle that saw no ack or err
        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                cnt <= '0;
            end else if (clr_i) begin
                cnt <= '0;
            end else if (en_i) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign expire_o = en_i && (cnt == CNT_W'(TIMEOUT - 1));
    end

endmodule

// File: rtl/iob_wb_master_bridge.sv
// Single-outstanding IOb slave port driving a Wishbone B4 master port,
// classic or pipelined, with optional posted writes and a bus watchdog.
module iob_wb_master_bridge
    import iob_wb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PIPELINED = 0,
    parameter int POSTED_WR = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  iob_valid_i,
    input  logic [ADDR_W-1:0]     iob_addr_i,
    input  logic [DATA_W-1:0]     iob_wdata_i,
    input  logic [DATA_W/8-1:0]   iob_wstrb_i,
    output logic [DATA_W-1:0]     iob_rdata_o,
    output logic                  iob_ready_o,
    output logic                  iob_err_o,
    output logic [ADDR_W-1:0]     wb_adr_o,
    output logic [DATA_W-1:0]     wb_dat_o,
    output logic [DATA_W/8-1:0]   wb_sel_o,
    output logic                  wb_we_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    input  logic [DATA_W-1:0]     wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_stall_i,
    output logic [ERR_CNT_W-1:0]  err_cnt_o
);

    state_t state;
    logic   posted_q;   // outstanding bus cycle was already answered on IOb
    logic   sticky_q;   // posted write failed, not yet reported
    logic   capture;
    logic   is_wr;
    logic   expire;
    logic   bus_fail;
    logic   bus_done;

    assign is_wr    = |iob_wstrb_i;
    assign capture  = (state == ST_IDLE) && iob_valid_i;
    assign bus_fail = wb_err_i || expire;
    assign bus_done = wb_ack_i || bus_fail;

    iob_wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .clr_i    (capture),
        .en_i     (wb_cyc_o && !wb_ack_i && !wb_err_i),
        .expire_o (expire)
    );

    // Request/response sequencer with registered IOb and Wishbone outputs
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state       <= ST_IDLE;
            posted_q    <= 1'b0;
            sticky_q    <= 1'b0;
            iob_rdata_o <= '0;
            iob_ready_o <= 1'b0;
            iob_err_o   <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
            wb_we_o     <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            iob_ready_o <= 1'b0;
            iob_err_o   <= 1'b0;
            iob_rdata_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (iob_valid_i) begin
                        wb_adr_o <= iob_addr_i;
                        wb_dat_o <= iob_wdata_i;
                        wb_we_o  <= is_wr;
                        wb_sel_o <= is_wr ? iob_wstrb_i : '1;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        state    <= ST_STB;
                        posted_q <= (POSTED_WR != 0) && is_wr;
                        if ((POSTED_WR != 0) && is_wr) begin
                            // Answer now; report any earlier posted failure
                            iob_ready_o <= 1'b1;
                            iob_err_o   <= sticky_q;
                            sticky_q    <= 1'b0;
                        end
                    end
                end
                ST_STB, ST_WAIT: begin
                    if (bus_done) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (bus_fail && (err_cnt_o != ERR_CNT_MAX)) begin
                            err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
                        end
                        if (posted_q) begin
                            state <= ST_IDLE;
                            if (bus_fail) begin
                                sticky_q <= 1'b1;
                            end
                        end else begin
                            state       <= ST_RESP;
                            iob_ready_o <= 1'b1;
                            iob_err_o   <= bus_fail || sticky_q;
                            sticky_q    <= 1'b0;
                            if (!bus_fail && !wb_we_o) begin
                                iob_rdata_o <= wb_dat_i;
                            end
                        end
                    end else if ((state == ST_STB) && (PIPELINED != 0) && !wb_stall_i) begin
                        // Request accepted by slave; keep cyc, wait for ack
                        wb_stb_o <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_wb_master_bridge.sv
// Bench for iob_wb_master_bridge: three instances (classic, pipelined,
// classic+posted writes, all TIMEOUT=8) driven by a cycle-level slave model.
module tb_iob_wb_master_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  valid_v;
    logic [31:0] addr, wdata, wb_dat;
    logic [3:0]  wstrb;
    logic        ack, err, stall;

    logic [31:0] rdata_v [3];
    logic [31:0] adr_v   [3];
    logic [31:0] dato_v  [3];
    logic [3:0]  sel_v   [3];
    logic [7:0]  ecnt_v  [3];
    logic [2:0]  ready_v, ierr_v, we_v, cyc_v, stb_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        iob_wb_master_bridge #(
            .ADDR_W    (32),
            .DATA_W    (32),
            .PIPELINED ((g == 1) ? 1 : 0),
            .POSTED_WR ((g == 2) ? 1 : 0),
            .TIMEOUT   (TMO)
        ) u_dut (
            .clk_i       (clk),
            .arst_n_i    (rst_n),
            .iob_valid_i (valid_v[g]),
            .iob_addr_i  (addr),
            .iob_wdata_i (wdata),
            .iob_wstrb_i (wstrb),
            .iob_rdata_o (rdata_v[g]),
            .iob_ready_o (ready_v[g]),
            .iob_err_o   (ierr_v[g]),
            .wb_adr_o    (adr_v[g]),
            .wb_dat_o    (dato_v[g]),
            .wb_sel_o    (sel_v[g]),
            .wb_we_o     (we_v[g]),
            .wb_cyc_o    (cyc_v[g]),
            .wb_stb_o    (stb_v[g]),
            .wb_dat_i    (wb_dat),
            .wb_ack_i    (ack),
            .wb_err_i    (err),
            .wb_stall_i  (stall),
            .err_cnt_o   (ecnt_v[g])
        );
    end

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rd;
        int          stbc;
        int          cycc;
        int          nrdy;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
    } obs_t;

    // resp: 0 ack, 1 err, 2 ack+err, 3 never answer
    typedef struct {
        int          d;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  st;
        int          w;
        int          resp;
        int          s;
        logic [31:0] sd;
        int          e_lat;
        logic        e_err;
        logic [31:0] e_rd;
        int          e_stb;
        logic [7:0]  e_ecnt;
    } vec_t;

    vec_t tbl [15];
    int   ecnt_m [3];

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Issue one IOb request to instance d and act as the Wishbone slave:
    // answer on the (w+1)-th cycle of cyc, stall the first s cycles.
    task automatic run_txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] st, input int w, input int resp,
                           input int s, input logic [31:0] sd, output obs_t o);
        int cc;
        bit done;
        o.lat = -1; o.err = 1'b0; o.rd = '0; o.stbc = 0; o.cycc = 0;
        o.nrdy = 0; o.adr = '0; o.sel = '0; o.we = 1'b0;
        addr = a; wdata = wd; wstrb = st; valid_v[d] = 1'b1;
        cc = 0; done = 1'b0;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(negedge clk);
            if (cyc_v[d]) begin
                cc++;
                if (cc == 1) begin
                    o.adr = adr_v[d]; o.sel = sel_v[d]; o.we = we_v[d];
                end
            end
            if (stb_v[d]) o.stbc++;
            if (ready_v[d]) begin
                o.nrdy++;
                if (o.lat < 0) begin
                    o.lat = i; o.err = ierr_v[d]; o.rd = rdata_v[d];
                end
                valid_v[d] = 1'b0;
            end
            ack = 1'b0; err = 1'b0; stall = 1'b0; wb_dat = '0;
            if (cyc_v[d]) begin
                if (resp != 3 && cc == w + 1) begin
                    ack = (resp != 1); err = (resp != 0); wb_dat = sd;
                end
                stall = (cc <= s);
            end else if (o.lat >= 0) begin
                done = 1'b1;
            end
        end
        o.cycc = cc;
        valid_v[d] = 1'b0; ack = 1'b0; err = 1'b0; stall = 1'b0;
        @(negedge clk);
        if (ready_v[d]) o.nrdy++;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    initial begin
        obs_t o;
        int d, w, resp, s, last, e_lat, e_stb;
        logic [31:0] a, wd, sd, e_rd;
        logic [3:0] st;
        logic e_err;

        tbl[0]  = '{0, 32'h100, 32'h0,        4'h0, 3, 0, 0, 32'hDEADBEEF, 5, 1'b0, 32'hDEADBEEF, 4, 8'd0};
        tbl[1]  = '{1, 32'h200, 32'h11223344, 4'h5, 4, 0, 2, 32'h0,        6, 1'b0, 32'h0,        3, 8'd0};
        tbl[2]  = '{0, 32'h104, 32'h0,        4'h0, 0, 3, 0, 32'h0,        9, 1'b1, 32'h0,        8, 8'd1};
        tbl[3]  = '{0, 32'h108, 32'h0,        4'h0, 7, 0, 0, 32'h5A5A5A5A, 9, 1'b0, 32'h5A5A5A5A, 8, 8'd1};
        tbl[4]  = '{0, 32'h10C, 32'hAAAA5555, 4'hF, 0, 2, 0, 32'h0,        2, 1'b1, 32'h0,        1, 8'd2};
        tbl[5]  = '{0, 32'h110, 32'h0,        4'h0, 1, 2, 0, 32'h0000FFFF, 3, 1'b1, 32'h0,        2, 8'd3};
        tbl[6]  = '{1, 32'h204, 32'h0,        4'h0, 0, 0, 0, 32'hCAFEF00D, 2, 1'b0, 32'hCAFEF00D, 1, 8'd0};
        tbl[7]  = '{1, 32'h208, 32'h0,        4'h0, 2, 1, 0, 32'h0,        4, 1'b1, 32'h0,        1, 8'd1};
        tbl[8]  = '{1, 32'h20C, 32'h0,        4'h0, 0, 3, 1, 32'h0,        9, 1'b1, 32'h0,        2, 8'd2};
        tbl[9]  = '{2, 32'h300, 32'h01020304, 4'h3, 2, 1, 0, 32'h0,        1, 1'b0, 32'h0,        3, 8'd1};
        tbl[10] = '{2, 32'h304, 32'h0,        4'h0, 0, 0, 0, 32'h12345678, 2, 1'b1, 32'h12345678, 1, 8'd1};
        tbl[11] = '{2, 32'h308, 32'h0,        4'h0, 0, 0, 0, 32'hABCD0000, 2, 1'b0, 32'hABCD0000, 1, 8'd1};
        tbl[12] = '{2, 32'h30C, 32'h55667788, 4'hF, 1, 0, 0, 32'h0,        1, 1'b0, 32'h0,        2, 8'd1};
        tbl[13] = '{2, 32'h310, 32'h99999999, 4'h8, 0, 3, 0, 32'h0,        1, 1'b0, 32'h0,        8, 8'd2};
        tbl[14] = '{2, 32'h314, 32'h77777777, 4'hC, 0, 0, 0, 32'h0,        1, 1'b1, 32'h0,        1, 8'd2};

        rst_n = 1'b0; valid_v = '0; addr = '0; wdata = '0; wstrb = '0;
        wb_dat = '0; ack = 1'b0; err = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("reset_outputs", g,
                64'(|{rdata_v[g], ready_v[g], ierr_v[g], adr_v[g], dato_v[g], sel_v[g],
                      we_v[g], cyc_v[g], stb_v[g], ecnt_v[g]}), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int k = 0; k < 15; k++) begin
            run_txn(tbl[k].d, tbl[k].a, tbl[k].wd, tbl[k].st, tbl[k].w, tbl[k].resp,
                    tbl[k].s, tbl[k].sd, o);
            chk("latency",   k, 64'(o.lat),  64'(tbl[k].e_lat));
            chk("iob_err",   k, 64'(o.err),  64'(tbl[k].e_err));
            chk("rdata",     k, 64'(o.rd),   64'(tbl[k].e_rd));
            chk("stb_cycles", k, 64'(o.stbc), 64'(tbl[k].e_stb));
            chk("err_cnt",   k, 64'(ecnt_v[tbl[k].d]), 64'(tbl[k].e_ecnt));
            chk("ready_pulses", k, 64'(o.nrdy), 64'd1);
            chk("wb_adr",    k, 64'(o.adr),  64'(tbl[k].a));
            chk("wb_sel",    k, 64'(o.sel),  64'((tbl[k].st == 4'h0) ? 4'hF : tbl[k].st));
            chk("wb_we",     k, 64'(o.we),   64'(tbl[k].st != 4'h0));
        end

        // Asynchronous reset in the middle of a strobe
        addr = 32'h400; wstrb = 4'h0; valid_v[0] = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_reset_cyc", 0, 64'(cyc_v[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_cyc_stb", 0, 64'({cyc_v[0], stb_v[0]}), 64'd0);
        valid_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_resp_after_rst", k, 64'({ready_v[0], cyc_v[0]}), 64'd0);
        end
        chk("err_cnt_cleared", 0, 64'(ecnt_v[0]), 64'd0);
        run_txn(0, 32'h404, 32'h0, 4'h0, 0, 0, 0, 32'h600DF00D, o);
        chk("post_rst_lat", 0, 64'(o.lat), 64'd2);
        chk("post_rst_rd",  0, 64'(o.rd),  64'h600DF00D);
        chk("post_rst_err", 0, 64'(o.err), 64'd0);

        // Randomized traffic against a rule-level model (non-posted instances)
        for (int g = 0; g < 3; g++) ecnt_m[g] = 0;
        for (int k = 0; k < 60; k++) begin
            d    = $urandom_range(0, 1);
            a    = $urandom;
            wd   = $urandom;
            sd   = $urandom;
            st   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            w    = $urandom_range(0, 9);
            resp = $urandom_range(0, 2);
            s    = $urandom_range(0, 3);
            run_txn(d, a, wd, st, w, resp, s, sd, o);
            if (w >= TMO) begin
                e_lat = TMO + 1; e_err = 1'b1; e_rd = '0; last = TMO;
            end else begin
                e_lat = w + 2; e_err = (resp != 0); last = w + 1;
                e_rd  = (e_err || st != 4'h0) ? 32'h0 : sd;
            end
            if (e_err) ecnt_m[d] = sat_inc(ecnt_m[d]);
            e_stb = (d == 1 && s + 1 < last) ? s + 1 : last;
            chk("rnd_latency", k, 64'(o.lat),  64'(e_lat));
            chk("rnd_err",     k, 64'(o.err),  64'(e_err));
            chk("rnd_rdata",   k, 64'(o.rd),   64'(e_rd));
            chk("rnd_stb",     k, 64'(o.stbc), 64'(e_stb));
            chk("rnd_cyc",     k, 64'(o.cycc), 64'(last));
            chk("rnd_err_cnt", k, 64'(ecnt_v[d]), 64'(ecnt_m[d]));
            chk("rnd_adr",     k, 64'(o.adr),  64'(a));
            chk("rnd_sel",     k, 64'(o.sel),  64'((st == 4'h0) ? 4'hF : st));
        end

        // Error counter saturation
        for (int k = 0; k < 300; k++) begin
            run_txn(0, 32'h500, 32'h0, 4'h0, 0, (k % 2 == 0) ? 1 : 2, 0, 32'hFFFFFFFF, o);
            if (k < 4) begin
                chk("forced_err_flag", k, 64'(o.err), 64'd1);
                chk("forced_err_rd",   k, 64'(o.rd),  64'd0);
            end
        end
        chk("err_cnt_saturated", 0, 64'(ecnt_v[0]), 64'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/iob_wb_master_bridge.md
IOB_WB_MASTER_BRIDGE -- requirements
Module: iob_wb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: IOb/Wishbone byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width, legal 32 or 64.
REQ-003 SHALL have parameter PIPELINED, default 0: 0 = Wishbone B4 classic, 1 = B4 pipelined (wb_stall_i honoured).
REQ-004 SHALL have parameter POSTED_WR, default 0: 1 = writes acknowledged to IOb before Wishbone completion.
REQ-005 SHALL have parameter TIMEOUT, default 255: cycles with wb_cyc_o high and no ack/err before abort; 0 disables.
REQ-006 SHALL have one clock and an asynchronous, active-low reset.
REQ-007 clk_i  in  1  sole clock, rising edge.
REQ-008 arst_n_i  in  1  async active-low reset.
REQ-009 iob_valid_i  in  1  request, held high until iob_ready_o.
REQ-010 iob_addr_i  in  ADDR_W  byte address.
REQ-011 iob_wdata_i  in  DATA_W  write data.
REQ-012 iob_wstrb_i  in  DATA_W/8  byte strobes; all-zero = read.
REQ-013 iob_rdata_o  out  DATA_W  read data, valid with iob_ready_o.
REQ-014 iob_ready_o  out  1  one-cycle response pulse.
REQ-015 iob_err_o  out  1  error flag, valid with iob_ready_o.
REQ-016 wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o/wb_cyc_o/wb_stb_o  out  ADDR_W/DATA_W/DATA_W/8/1/1/1  Wishbone master outputs.
REQ-017 wb_dat_i/wb_ack_i/wb_err_i/wb_stall_i  in  DATA_W/1/1/1  Wishbone master inputs.
REQ-018 err_cnt_o  out  8  saturating count of bus errors plus timeouts.

Function
REQ-019 FSM states: IDLE, STB (wb_stb_o high), WAIT (pipelined only: stb low, awaiting ack), RESP.
REQ-020 IDLE and iob_valid_i at edge N: capture addr/wdata/wstrb; wb_cyc_o=wb_stb_o=1 from N+1; -> STB.
REQ-021 Read: wb_we_o=0, wb_sel_o all ones; write: wb_we_o=1, wb_sel_o=iob_wstrb_i.
REQ-022 Classic: wb_stb_o held until wb_ack_i or wb_err_i; wb_stall_i ignored.
REQ-023 Pipelined: stb dropped the cycle after stb high with wb_stall_i=0 (-> WAIT); ack/err in that same cycle accepted directly.
REQ-024 Ack/err at edge K: wb_cyc_o and wb_stb_o low from K+1; iob_ready_o=1 for exactly cycle K+1 (RESP), rdata registered from wb_dat_i (0 for writes); -> IDLE.
REQ-025 Minimum latency iob_valid_i to iob_ready_o: 2 cycles (ack in first stb cycle).
REQ-026 wb_ack_i and wb_err_i together: err wins; iob_err_o=1, iob_rdata_o=0.
REQ-027 Timeout: counter clears when cyc rises, increments each cycle cyc high without ack/err; at TIMEOUT, abort: cyc/stb low next cycle, response with iob_err_o=1, rdata=0.
REQ-028 Ack arriving the same cycle the counter reaches TIMEOUT: ack wins, no error.
REQ-029 POSTED_WR=1 write: iob_ready_o=1 in cycle N+1 (with cyc/stb rise); Wishbone completes in background; iob_ready_o not asserted again until bus idle.
REQ-030 Posted-write error or timeout: sets sticky flag; flag reported as iob_err_o on next IOb response of any kind, then cleared.
REQ-031 err_cnt_o increments by 1 on every wb_err_i response and every timeout; saturates at 255.
REQ-032 Requests presented while busy are not captured until IDLE; iob_valid_i may reassert the cycle after iob_ready_o.

Reset
REQ-033 arst_n_i low: immediately (asynchronously) all outputs 0, FSM IDLE, timeout counter 0, sticky flag 0, err_cnt_o 0.
REQ-034 Reset mid-transaction: wb_cyc_o/wb_stb_o drop without waiting for ack; no IOb response issued for the aborted request.

Structure
REQ-035 Shared package iob_wb_pkg: FSM state encoding, timeout counter width function clog2(TIMEOUT+1), err_cnt saturation constant.
REQ-036 One sub-module iob_wb_timeout: clear/enable counter with expiry pulse and TIMEOUT=0 bypass.

Verification
REQ-037 Classic read addr 0x100, slave ack after 3 wait states with 0xDEADBEEF -> iob_ready_o 5 cycles after valid, rdata 0xDEADBEEF, err 0.
REQ-038 Pipelined write wstrb 4'b0101, wb_stall_i high 2 cycles -> stb held 3 cycles, wb_sel_o=4'b0101, one response pulse.
REQ-039 Slave never acks, TIMEOUT=8 -> cyc drops after 8 cycles, iob_err_o=1, err_cnt_o=1.
REQ-040 POSTED_WR=1 write answered with wb_err_i, then read acked -> write ready immediate, read response iob_err_o=1, sticky cleared afterwards.
REQ-041 ack and err asserted together -> iob_err_o=1, rdata 0; 300 forced errors -> err_cnt_o=255.
REQ-042 arst_n_i pulsed low mid-STB -> cyc/stb low same cycle, no iob_ready_o, next request served normally.
